// File: rtl/fft_bin_reader_if.sv
// rtl/fft_bin_reader_if.sv - result-RAM read port and bin output stream between reader and its neighbours
interface fft_bin_reader_if #(
    parameter int N_LOG2 = 4,
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic [N_LOG2-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [N_LOG2-1:0] out_idx;
    logic              out_last;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_idx, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_idx, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/fft_bin_reader.sv
// rtl/fft_bin_reader.sv - reads N FFT bins from the result RAM in natural order and streams them out
module fft_bin_reader #(
    parameter int N_LOG2 = 4,
    parameter int DATA_W = 32,
    parameter int BITREV = 1
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    fft_bin_reader_if.master    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    state_t            state, state_nx;
    logic [N_LOG2-1:0] cnt;
    logic [N_LOG2-1:0] tag_q;
    logic [N_LOG2-1:0] addr_q;
    logic [N_LOG2-1:0] issue_addr;
    logic              inflight;
    logic [1:0]        occ;
    logic [1:0]        occ_nx;
    logic [1:0]        occ_after_pop;
    logic [2:0]        pending;
    logic              pop;
    logic              issue;
    logic [DATA_W-1:0] data0, data1;
    logic [N_LOG2-1:0] idx0, idx1;

    function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = v[N_LOG2-1-i];
        end
        return r;
    endfunction

    // Words already buffered plus the one returning this edge, minus the one leaving now.
    assign pop           = (occ != 2'd0) && bus.out_ready;
    assign pending       = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign occ_nx        = pending[1:0];
    assign occ_after_pop = occ - {1'b0, pop};
    assign issue         = (state == S_RUN) && (pending < 3'd2);
    assign issue_addr    = (BITREV != 0) ? bit_rev(cnt) : cnt;

    assign bus.rd_en     = issue;
    assign bus.rd_addr   = issue ? issue_addr : addr_q;
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = data0;
    assign bus.out_idx   = idx0;
    assign bus.out_last  = (occ != 2'd0) && (idx0 == LAST_IDX);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (issue && (cnt == LAST_IDX)) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!inflight && (occ_nx == 2'd0)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt      <= '0;
            tag_q    <= '0;
            addr_q   <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            data0    <= '0;
            data1    <= '0;
            idx0     <= '0;
            idx1     <= '0;
        end else begin
            inflight <= issue;
            occ      <= occ_nx;
            if ((state == S_IDLE) && start) begin
                cnt <= '0;
            end else if (issue) begin
                cnt    <= cnt + 1'b1;
                tag_q  <= cnt;
                addr_q <= issue_addr;
            end
            if (pop) begin
                data0 <= data1;
                idx0  <= idx1;
            end
            // A returning word lands behind whatever survives this cycle's pop.
            if (inflight) begin
                if (occ_after_pop == 2'd0) begin
                    data0 <= bus.rd_data;
                    idx0  <= tag_q;
                end else begin
                    data1 <= bus.rd_data;
                    idx1  <= tag_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_bin_reader.sv
// tb/tb_fft_bin_reader.sv - directed scoreboard bench for fft_bin_reader with bit-reversed and natural addressing
module tb_fft_bin_reader;
    localparam int NL = 4;
    localparam int DW = 32;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic start_br = 1'b0;
    logic start_nb = 1'b0;
    logic busy_br, done_br, busy_nb, done_nb;

    fft_bin_reader_if #(.N_LOG2(NL), .DATA_W(DW)) if_br ();
    fft_bin_reader_if #(.N_LOG2(NL), .DATA_W(DW)) if_nb ();

    fft_bin_reader #(.N_LOG2(NL), .DATA_W(DW), .BITREV(1)) dut_br (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start_br),
        .busy  (busy_br),
        .done  (done_br),
        .bus   (if_br.master)
    );

    fft_bin_reader #(.N_LOG2(NL), .DATA_W(DW), .BITREV(0)) dut_nb (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start_nb),
        .busy  (busy_nb),
        .done  (done_nb),
        .bus   (if_nb.master)
    );

    always #5 clk = ~clk;

    // Result RAMs: bit-reversed DUT sees RAM[a]=a, natural DUT sees RAM[a]=0xA000+a.
    always @(posedge clk) begin
        if (if_br.rd_en) if_br.rd_data <= 32'(if_br.rd_addr);
        if (if_nb.rd_en) if_nb.rd_data <= 32'hA000 + 32'(if_nb.rd_addr);
    end

    int checks = 0;
    int errors = 0;
    int br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic [63:0] q_br [$];
    logic [63:0] q_nb [$];
    int beats_br = 0, beats_nb = 0, issued_br = 0, issued_nb = 0, dones_br = 0, dones_nb = 0;
    logic stall_br = 1'b0, stall_nb = 1'b0;
    logic [63:0] held_br, held_nb, word_br, word_nb, exp_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int idx, input logic [31:0] data);
        return {27'd0, (idx == N - 1), 4'(idx), data};
    endfunction

    always @(negedge clk) begin
        if (!clr_n) begin
            beats_br = 0; beats_nb = 0; issued_br = 0; issued_nb = 0;
            stall_br = 1'b0; stall_nb = 1'b0;
        end else begin
            word_br = {27'd0, if_br.out_last, if_br.out_idx, if_br.out_data};
            word_nb = {27'd0, if_nb.out_last, if_nb.out_idx, if_nb.out_data};
            if (stall_br) begin
                check("br_stall_valid", if_br.out_valid, 1);
                check("br_stall_word", word_br, held_br);
            end
            if (stall_nb) begin
                check("nb_stall_valid", if_nb.out_valid, 1);
                check("nb_stall_word", word_nb, held_nb);
            end
            stall_br = if_br.out_valid && !if_br.out_ready;
            stall_nb = if_nb.out_valid && !if_nb.out_ready;
            held_br  = word_br;
            held_nb  = word_nb;
            if (if_br.rd_en) issued_br++;
            if (if_nb.rd_en) issued_nb++;
            if (done_br) dones_br++;
            if (done_nb) dones_nb++;
            if (if_br.out_valid && if_br.out_ready) begin
                beats_br++;
                check("br_beat_expected", q_br.size() != 0, 1);
                if (q_br.size() != 0) begin
                    exp_w = q_br.pop_front();
                    check("br_beat", word_br, exp_w);
                end
            end
            if (if_nb.out_valid && if_nb.out_ready) begin
                beats_nb++;
                check("nb_beat_expected", q_nb.size() != 0, 1);
                if (q_nb.size() != 0) begin
                    exp_w = q_nb.pop_front();
                    check("nb_beat", word_nb, exp_w);
                end
            end
            check("br_occupancy", (issued_br - beats_br) <= 2, 1);
            check("nb_occupancy", (issued_nb - beats_nb) <= 2, 1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_beats, base_issued, base_dones;
        logic [4:0] exp_ctrl;

        if_br.out_ready = 1'b1;
        if_nb.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_br", {busy_br, done_br, if_br.rd_en, if_br.rd_addr, if_br.out_valid,
                                   if_br.out_data, if_br.out_idx, if_br.out_last}, 0);
        check("reset_outputs_nb", {busy_nb, done_nb, if_nb.rd_en, if_nb.rd_addr, if_nb.out_valid,
                                   if_nb.out_data, if_nb.out_idx, if_nb.out_last}, 0);
        clr_n = 1'b1;
        @(posedge clk); #1;

        // Full-rate bit-reversed readout with cycle-exact control timing.
        base_dones = dones_br;
        for (int i = 0; i < N; i++) q_br.push_back(mk(i, 32'(br_tab[i])));
        start_br = 1'b1;
        @(posedge clk); #1;
        start_br = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            exp_ctrl = {c <= 16, (c >= 3 && c <= 18), c == 18, c == 19, c <= 18};
            check("t1_ctrl", {if_br.rd_en, if_br.out_valid, if_br.out_last, done_br, busy_br}, exp_ctrl);
            if (c <= 16) check("t1_rd_addr", if_br.rd_addr, br_tab[c-1]);
            if (c >= 3 && c <= 18) check("t1_out_idx", if_br.out_idx, c - 3);
        end
        @(posedge clk); #1;
        check("t1_queue_drained", q_br.size(), 0);
        check("t1_done_count", dones_br - base_dones, 1);

        // Natural addressing with out_ready toggling every cycle.
        base_beats = beats_nb;
        for (int i = 0; i < N; i++) q_nb.push_back(mk(i, 32'hA000 + 32'(i)));
        start_nb = 1'b1;
        @(posedge clk); #1;
        start_nb = 1'b0;
        for (int c = 1; c < 200; c++) begin
            if (q_nb.size() == 0 && !busy_nb) break;
            if_nb.out_ready = (c % 2) == 1;
            @(posedge clk); #1;
        end
        if_nb.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t2_queue_drained", q_nb.size(), 0);
        check("t2_beats", beats_nb - base_beats, 16);
        check("t2_done_count", dones_nb, 1);

        // Long backpressure right after start: only two reads may be outstanding.
        base_issued = issued_br;
        base_dones  = dones_br;
        for (int i = 0; i < N; i++) q_br.push_back(mk(i, 32'(br_tab[i])));
        start_br = 1'b1;
        @(posedge clk); #1;
        start_br = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if_br.out_ready = !(c >= 2);
            @(negedge clk);
            check("t3_rd_en", if_br.rd_en, c <= 2);
            check("t3_out_valid", if_br.out_valid, c >= 3);
            if (c >= 3) begin
                check("t3_out_idx", if_br.out_idx, 0);
                check("t3_rd_addr_hold", if_br.rd_addr, 8);
            end
            @(posedge clk); #1;
        end
        check("t3_reads_issued", issued_br - base_issued, 2);
        if_br.out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (q_br.size() == 0 && !busy_br) break;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("t3_queue_drained", q_br.size(), 0);
        check("t3_done_count", dones_br - base_dones, 1);

        // Stray starts during RUN/DRAIN and on the done cycle, then a clean restart.
        base_beats = beats_br;
        base_dones = dones_br;
        for (int i = 0; i < N; i++) q_br.push_back(mk(i, 32'(br_tab[i])));
        start_br = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 24; c++) begin
            start_br = (c == 5 || c == 10 || c == 19 || c == 21);
            if (c == 21) begin
                for (int i = 0; i < N; i++) q_br.push_back(mk(i, 32'(br_tab[i])));
            end
            @(negedge clk);
            if (c == 19) check("t4_done_pulse", done_br, 1);
            if (c == 20) check("t4_idle_after_done", {busy_br, done_br}, 0);
            if (c == 22) check("t4_restart_busy", busy_br, 1);
            @(posedge clk); #1;
        end
        start_br = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (q_br.size() == 0 && !busy_br) break;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("t4_queue_drained", q_br.size(), 0);
        check("t4_beats", beats_br - base_beats, 32);
        check("t4_done_count", dones_br - base_dones, 2);

        // Reset in the middle of a readout.
        for (int i = 0; i < N; i++) q_br.push_back(mk(i, 32'(br_tab[i])));
        start_br = 1'b1;
        @(posedge clk); #1;
        start_br = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        clr_n = 1'b0;
        #1;
        check("t5_reset_outputs", {busy_br, done_br, if_br.rd_en, if_br.rd_addr, if_br.out_valid,
                                   if_br.out_data, if_br.out_idx, if_br.out_last}, 0);
        q_br.delete();
        @(posedge clk); #1;
        clr_n = 1'b1;
        for (int c = 9; c <= 13; c++) begin
            @(negedge clk);
            check("t5_no_late_data", {if_br.out_valid, busy_br, if_br.rd_en}, 0);
            @(posedge clk); #1;
        end
        base_dones = dones_br;
        for (int i = 0; i < N; i++) q_br.push_back(mk(i, 32'(br_tab[i])));
        start_br = 1'b1;
        @(posedge clk); #1;
        start_br = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_first_idx", {if_br.out_valid, if_br.out_idx}, {1'b1, 4'd0});
        for (int k = 0; k < 200; k++) begin
            if (q_br.size() == 0 && !busy_br) break;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("t5_queue_drained", q_br.size(), 0);
        check("t5_beats", beats_br, 16);
        check("t5_done_count", dones_br - base_dones, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_bin_reader.md
Name: fft_bin_reader

Overview:
- Read-side counterpart to the FFT result-memory writer.
- After the FFT core finishes writing N complex bins into the synchronous result RAM, this block reads them back in natural bin order. With BITREV=1 it applies bit-reversed addresses, since the core writes in bit-reversed order.
- Bins are streamed out on a valid/ready interface toward the magnitude/output stage.
- A 2-entry output buffer absorbs the RAM's 1-cycle read latency under backpressure without dropping or duplicating words.

Parameters:
- N_LOG2, 4, log2 of transform size N (N = 16 by default).
- DATA_W, 32, bin word width ({real[15:0], imag[15:0]}); passed through unmodified.
- BITREV, 1, 1 = rd_addr is the bit-reverse of the bin index; 0 = rd_addr equals the bin index.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a readout; ignored unless in IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the final output handshake.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  N_LOG2  RAM read address.
- rd_data  in  DATA_W  RAM read data, valid the cycle after rd_en.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  bin value.
- out_idx  out  N_LOG2  natural bin index of out_data.
- out_last  out  1  high with the word whose out_idx = N-1.

Behaviour:
- Reset:
  - Asynchronous assertion of clr_n returns the FSM to IDLE.
  - It clears the issue counter, in-flight flag and buffer occupancy.
  - All outputs go to 0, including busy, done, rd_en, rd_addr, out_valid, out_data, out_idx and out_last.
  - Reset mid-readout abandons the transfer. A read returning after release is discarded.
- FSM states:
  - IDLE: start=1 → RUN; counter cnt := 0.
  - RUN: issue reads. When the read for cnt = N-1 is issued → DRAIN.
  - DRAIN: no reads. When in-flight = 0, buffer empty and the last handshake is complete → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Read issue:
  - In RUN, rd_en=1 iff (occ + inflight − pop) < 2, where pop = out_valid & out_ready.
  - On issue: rd_addr = BITREV ? bitrev(cnt) : cnt; the tag cnt is captured alongside; cnt increments.
  - rd_addr holds its last value when rd_en=0.
- Capture: rd_data plus tag enter the buffer tail on the cycle after rd_en. Capture and pop in the same cycle are both honoured.
- Output stream:
  - out_valid = occ > 0.
  - out_data, out_idx and out_last come from the buffer head.
  - While out_valid=1 and out_ready=0, out_data, out_idx and out_last stay stable and out_valid stays high.
- Order: words leave strictly in out_idx order 0..N-1, each exactly once.
- Throughput:
  - One word per cycle with out_ready held high.
  - Latency: start in cycle 0 → rd_en in cycle 1 → first out_valid in cycle 3.
- Boundary conditions:
  - occ never exceeds 2.
  - start during RUN, DRAIN or DONE is ignored.
  - start in the same cycle done pulses is ignored. A new start is accepted from the following IDLE cycle.
  - N_LOG2 counter wrap is never observed, because issue stops at N-1.

Test Plan:
- N_LOG2=4, BITREV=1, RAM[a]=a, out_ready=1, start in cycle 0 → rd_addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 in cycles 1–16; out_valid cycles 3–18; out_data follows the same sequence; out_idx 0..15; out_last only in cycle 18; done only in cycle 19; busy cycles 1–18.
- BITREV=0, RAM[a]=0xA000+a, out_ready toggling 1,0,1,0 → 16 beats with out_data 0xA000..0xA00F in order; no gaps or duplicates; occ never exceeds 2; out_data stable on every cycle with valid=1, ready=0.
- out_ready=0 from cycle 2 to cycle 20 → exactly 2 reads issued (cycles 1,2); rd_en low thereafter; out_valid high with out_idx=0 throughout; after ready rises, all 16 beats are delivered correctly.
- Repeated start pulses at cycles 5 and 10 during a readout, plus start coincident with done → no restart; exactly 16 beats; one done pulse; a second start two cycles after done runs a complete new readout.
- clr_n low for 1 cycle at cycle 8 of a readout → all outputs 0 immediately; FSM in IDLE; the late rd_data is not emitted; the next start produces a clean 16-beat readout from out_idx=0.
